// File: rtl/lvt_pkg.sv
// lvt_pkg: shared types and defaults for the LVT RAM write front end.
//   LVT_ADDR_W / LVT_DATA_W / LVT_NPORT : default geometry of ram_8R8W
//   lvt_state_e                        : front-end FSM states
//   slice_lo()                         : low bit of lane k in a flat packed bus
package lvt_pkg;
  localparam int LVT_ADDR_W = 11;
  localparam int LVT_DATA_W = 32;
  localparam int LVT_NPORT  = 8;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} lvt_state_e;

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/lvt_wr_conflict.sv
// lvt_wr_conflict: same-cycle write collision filter (combinational).
//   in_en     [NPORT]        : client write enables
//   in_addr   [NPORT*ADDR_W] : client addresses, lane k at [k*ADDR_W +: ADDR_W]
//   en_filt   [NPORT]        : enables with losing lanes cleared
//   collision                : at least one lane was cleared
// On a shared address the highest-index lane wins; every lower lane that
// matches any enabled higher lane is dropped, so N-way collisions collapse
// to the single top lane.
module lvt_wr_conflict #(
  parameter int ADDR_W = 11,
  parameter int NPORT  = 8
) (
  input  logic [NPORT-1:0]        in_en,
  input  logic [NPORT*ADDR_W-1:0] in_addr,
  output logic [NPORT-1:0]        en_filt,
  output logic                    collision
);
  logic [NPORT-1:0][ADDR_W-1:0] addr_v;
  logic [NPORT-1:0]             kill;

  assign addr_v = in_addr;

  always_comb begin
    kill = '0;
    for (int j = 0; j < NPORT; j++)
      for (int k = j + 1; k < NPORT; k++)
        if (in_en[j] && in_en[k] && (addr_v[j] == addr_v[k]))
          kill[j] = 1'b1;
  end

  assign en_filt   = in_en & ~kill;
  assign collision = |kill;
endmodule

// File: rtl/lvt_write_front.sv
// lvt_write_front: write-side front end for the 8R8W LVT RAM.
//   clk, rst (sync, active-high)
//   init_req              : request a full RAM re-clear (ignored mid-sweep)
//   in_en/in_addr/in_din  : client write lanes, flat packed buses
//   ready                 : client writes accepted (RUN)
//   init_done             : one-cycle pulse, first RUN cycle after a sweep
//   conflict              : one-cycle pulse aligned with filtered writes
//   wr_err                : sticky, client write attempted while not ready
//   w_enb/w_addr/w_din    : registered drive of RAM write ports 1..NPORT
// CLEAR sweeps NPORT consecutive addresses per cycle with CLEAR_VAL; RUN
// forwards conflict-filtered client writes with one register of latency.
module lvt_write_front
  import lvt_pkg::*;
#(
  parameter int                 ADDR_W    = LVT_ADDR_W,
  parameter int                 DATA_W    = LVT_DATA_W,
  parameter int                 NPORT     = LVT_NPORT,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_req,
  input  logic [NPORT-1:0]        in_en,
  input  logic [NPORT*ADDR_W-1:0] in_addr,
  input  logic [NPORT*DATA_W-1:0] in_din,
  output logic                    ready,
  output logic                    init_done,
  output logic                    conflict,
  output logic                    wr_err,
  output logic [NPORT-1:0]        w_enb,
  output logic [NPORT*ADDR_W-1:0] w_addr,
  output logic [NPORT*DATA_W-1:0] w_din
);
  localparam int PW    = $clog2(NPORT);
  localparam int CNT_W = ADDR_W - PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lvt_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [NPORT-1:0] en_filt;
  logic             coll;

  lvt_wr_conflict #(.ADDR_W(ADDR_W), .NPORT(NPORT)) u_conflict (
    .in_en    (in_en),
    .in_addr  (in_addr),
    .en_filt  (en_filt),
    .collision(coll)
  );

  assign ready = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == CNT_MAX) state_nxt = RUN;
      RUN:     if (init_req)       state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      w_enb     <= '0;
      w_addr    <= '0;
      w_din     <= '0;
      init_done <= 1'b0;
      conflict  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      init_done <= 1'b0;
      conflict  <= 1'b0;
      if (state == CLEAR) begin
        // Lane k of sweep step c covers address c*NPORT+k; the counter
        // wraps to 0 on the last step so RUN starts with it cleared.
        cnt       <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        init_done <= (cnt == CNT_MAX);
        w_enb     <= '1;
        for (int k = 0; k < NPORT; k++) begin
          w_addr[slice_lo(k, ADDR_W) +: ADDR_W] <= {cnt, PW'(k)};
          w_din[slice_lo(k, DATA_W) +: DATA_W]  <= CLEAR_VAL;
        end
        // Client writes during the sweep are dropped, only flagged.
        if (|in_en) wr_err <= 1'b1;
      end else begin
        cnt      <= '0;
        w_enb    <= en_filt;
        conflict <= coll;
        // Idle lanes keep their last address/data.
        for (int k = 0; k < NPORT; k++)
          if (in_en[k]) begin
            w_addr[slice_lo(k, ADDR_W) +: ADDR_W] <= in_addr[slice_lo(k, ADDR_W) +: ADDR_W];
            w_din[slice_lo(k, DATA_W) +: DATA_W]  <= in_din[slice_lo(k, DATA_W) +: DATA_W];
          end
      end
    end
  end
endmodule
